// File: rtl/eth_mdio_pkg.sv
// Shared types and constants for the clause-22 MDIO management responder.
`timescale 1ns/1ps
package eth_mdio_pkg;
   typedef enum logic [2:0] {PRE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA} mdio_state_t;

   localparam logic [1:0] MDIO_OP_READ  = 2'b10;
   localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
   localparam int         MDIO_PRE_MAX  = 32;
endpackage

// File: rtl/mdio_sync.sv
// Double-flop synchronizers for MDC and MDIO with an MDC rising-edge pulse.
`timescale 1ns/1ps
module mdio_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic mdc,
   input  logic i_mdio,
   output logic mdc_rise,
   output logic mdio_s
);
   logic [1:0] mdc_sync_q, mdc_sync_d;
   logic [1:0] mdio_sync_q, mdio_sync_d;
   logic       mdc_prev_q, mdc_prev_d;

   always_comb begin
      mdc_sync_d  = {mdc_sync_q[0], mdc};
      mdio_sync_d = {mdio_sync_q[0], i_mdio};
      mdc_prev_d  = mdc_sync_q[1];
   end

   // MDIO idles high through its pull-up, so its synchronizer resets to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdc_sync_q  <= 2'b00;
         mdio_sync_q <= 2'b11;
         mdc_prev_q  <= 1'b0;
      end else begin
         mdc_sync_q  <= mdc_sync_d;
         mdio_sync_q <= mdio_sync_d;
         mdc_prev_q  <= mdc_prev_d;
      end
   end

   assign mdc_rise = mdc_sync_q[1] & ~mdc_prev_q;
   assign mdio_s   = mdio_sync_q[1];
endmodule

// File: rtl/eth_mdio_slave.sv
// Clause-22 MDIO PHY-side responder: decodes frames sampled on MDC rising edges,
// serves reads from an external register file and issues write strobes.
`timescale 1ns/1ps
module eth_mdio_slave
   import eth_mdio_pkg::*;
#(
   parameter int PRE_LEN  = 32,
   parameter bit BCAST_EN = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  phy_addr,
   input  logic        mdc,
   input  logic        i_mdio,
   output logic        o_mdio,
   output logic        t_mdio,
   output logic [4:0]  reg_addr,
   output logic        reg_rd,
   input  logic [15:0] reg_rdata,
   output logic        reg_we,
   output logic [15:0] reg_wdata,
   output logic        busy
);
   localparam logic [5:0] PRE_LEN_W = 6'(PRE_LEN);
   localparam logic [5:0] PRE_MAX_W = 6'(MDIO_PRE_MAX);

   logic mdc_rise, mdio_s;

   mdio_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .mdc      (mdc),
      .i_mdio   (i_mdio),
      .mdc_rise (mdc_rise),
      .mdio_s   (mdio_s)
   );

   mdio_state_t state_q, state_d;
   logic [5:0]  pre_cnt_q, pre_cnt_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]  op_q, op_d;
   logic [14:0] sh_q, sh_d;
   logic [4:0]  regad_q, regad_d;
   logic        match_q, match_d;
   logic        ta_q, ta_d;
   logic [15:0] rdata_q, rdata_d;
   logic        rd_pend_q, rd_pend_d;
   logic        o_mdio_q, o_mdio_d;
   logic        t_mdio_q, t_mdio_d;
   logic        busy_q, busy_d;
   logic        reg_rd_q, reg_rd_d;
   logic        reg_we_q, reg_we_d;
   logic [4:0]  reg_addr_q, reg_addr_d;
   logic [15:0] reg_wdata_q, reg_wdata_d;
   logic [4:0]  field5;
   logic        to_pre;

   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      op_d        = op_q;
      sh_d        = sh_q;
      regad_d     = regad_q;
      match_d     = match_q;
      ta_d        = ta_q;
      rdata_d     = rdata_q;
      o_mdio_d    = o_mdio_q;
      t_mdio_d    = t_mdio_q;
      busy_d      = busy_q;
      reg_rd_d    = 1'b0;
      reg_we_d    = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      to_pre      = 1'b0;
      field5      = {sh_q[3:0], mdio_s};

      // Register file answers one clk after the reg_rd pulse; capture it the clk after that.
      rd_pend_d = reg_rd_q;
      if (rd_pend_q) rdata_d = reg_rdata;

      if (mdc_rise) begin
         case (state_q)
            PRE: begin
               if (mdio_s) begin
                  if (pre_cnt_q != PRE_MAX_W) pre_cnt_d = pre_cnt_q + 6'd1;
               end else if (pre_cnt_q >= PRE_LEN_W) begin
                  state_d   = ST;
                  busy_d    = 1'b1;
                  pre_cnt_d = 6'd0;
               end else begin
                  pre_cnt_d = 6'd0;
               end
            end
            ST: begin
               if (mdio_s) begin
                  state_d   = OP;
                  bit_cnt_d = 5'd0;
               end else begin
                  to_pre = 1'b1;
               end
            end
            OP: begin
               op_d = {op_q[0], mdio_s};
               if (bit_cnt_q == 5'd0) begin
                  bit_cnt_d = 5'd1;
               end else if (op_d == MDIO_OP_READ || op_d == MDIO_OP_WRITE) begin
                  state_d   = PHYAD;
                  bit_cnt_d = 5'd0;
               end else begin
                  to_pre = 1'b1;
               end
            end
            PHYAD: begin
               sh_d = {sh_q[13:0], mdio_s};
               if (bit_cnt_q == 5'd4) begin
                  match_d = (field5 == phy_addr) ||
                            (op_q == MDIO_OP_WRITE && BCAST_EN && field5 == 5'd0);
                  state_d   = REGAD;
                  bit_cnt_d = 5'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            REGAD: begin
               sh_d = {sh_q[13:0], mdio_s};
               if (bit_cnt_q == 5'd4) begin
                  regad_d = field5;
                  if (op_q == MDIO_OP_READ && match_q) begin
                     reg_rd_d   = 1'b1;
                     reg_addr_d = field5;
                  end
                  state_d   = TA;
                  bit_cnt_d = 5'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            TA: begin
               if (bit_cnt_q == 5'd0) begin
                  ta_d      = mdio_s;
                  bit_cnt_d = 5'd1;
                  if (op_q == MDIO_OP_READ && match_q) begin
                     t_mdio_d = 1'b0;
                     o_mdio_d = 1'b0;
                  end
               end else if (op_q == MDIO_OP_READ) begin
                  if (match_q) begin
                     o_mdio_d = rdata_q[15];
                     rdata_d  = {rdata_q[14:0], 1'b0};
                  end
                  state_d   = RDATA;
                  bit_cnt_d = 5'd0;
               end else if ({ta_q, mdio_s} == 2'b10) begin
                  state_d   = WDATA;
                  bit_cnt_d = 5'd0;
               end else begin
                  to_pre = 1'b1;
               end
            end
            RDATA: begin
               // D15 already went out in TA; 15 more bits, then one edge to release.
               if (bit_cnt_q == 5'd15) begin
                  to_pre = 1'b1;
               end else begin
                  if (match_q) begin
                     o_mdio_d = rdata_q[15];
                     rdata_d  = {rdata_q[14:0], 1'b0};
                  end
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            WDATA: begin
               sh_d = {sh_q[13:0], mdio_s};
               if (bit_cnt_q == 5'd15) begin
                  if (match_q) begin
                     reg_we_d    = 1'b1;
                     reg_addr_d  = regad_q;
                     reg_wdata_d = {sh_q, mdio_s};
                  end
                  to_pre = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
            default: to_pre = 1'b1;
         endcase
      end

      if (to_pre) begin
         state_d   = PRE;
         pre_cnt_d = 6'd0;
         busy_d    = 1'b0;
         t_mdio_d  = 1'b1;
         o_mdio_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PRE;
         pre_cnt_q   <= 6'd0;
         bit_cnt_q   <= 5'd0;
         op_q        <= 2'b00;
         sh_q        <= 15'd0;
         regad_q     <= 5'd0;
         match_q     <= 1'b0;
         ta_q        <= 1'b0;
         rdata_q     <= 16'd0;
         rd_pend_q   <= 1'b0;
         o_mdio_q    <= 1'b1;
         t_mdio_q    <= 1'b1;
         busy_q      <= 1'b0;
         reg_rd_q    <= 1'b0;
         reg_we_q    <= 1'b0;
         reg_addr_q  <= 5'd0;
         reg_wdata_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         op_q        <= op_d;
         sh_q        <= sh_d;
         regad_q     <= regad_d;
         match_q     <= match_d;
         ta_q        <= ta_d;
         rdata_q     <= rdata_d;
         rd_pend_q   <= rd_pend_d;
         o_mdio_q    <= o_mdio_d;
         t_mdio_q    <= t_mdio_d;
         busy_q      <= busy_d;
         reg_rd_q    <= reg_rd_d;
         reg_we_q    <= reg_we_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
      end
   end

   assign o_mdio    = o_mdio_q;
   assign t_mdio    = t_mdio_q;
   assign busy      = busy_q;
   assign reg_rd    = reg_rd_q;
   assign reg_we    = reg_we_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
endmodule
